// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcode field, WFI code
// and the fetch controller state encoding.
package ifu_fetch_pkg;

    localparam int OP_HI = 63;
    localparam int OP_LO = 56;
    localparam logic [OP_HI-OP_LO:0] WFI_OP_CODE = 8'hF3;

    typedef enum logic [1:0] {
        IFU_ST_IDLE  = 2'd0,
        IFU_ST_FETCH = 2'd1,
        IFU_ST_DRAIN = 2'd2,
        IFU_ST_DONE  = 2'd3
    } ifu_st_e;

    function automatic logic is_wfi(input logic [63:0] word);
        return word[OP_HI:OP_LO] == WFI_OP_CODE;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Two-entry instruction queue; entry 0 is always the head. Flush wins over push.
module ifu_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] din,
    output logic [1:0]  count,
    output logic [63:0] head
);

    logic [63:0] e0;
    logic [63:0] e1;
    logic        do_pop;

    assign head   = e0;
    assign do_pop = pop && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            e0    <= 64'd0;
            e1    <= 64'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; pop shifts the head before the new word lands
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: reads words from the synchronous SRAM into a small queue
// and hands them to the IDU until a WFI is transferred, then waits for it to retire.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int IMEM_AW    = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IMEM_AW-1:0] start_pc,
    output logic               ifu_imem_req,
    output logic [IMEM_AW-1:0] ifu_imem_addr,
    input  logic [63:0]        imem_ifu_rdata,
    output logic               ifu_idu_vld,
    output logic [63:0]        ifu_idu_ins,
    input  logic               idu_ifu_rdy,
    input  logic               idu_ifu_wfi,
    output logic               ifu_busy,
    output logic               ifu_done
);

    ifu_st_e            state;
    ifu_st_e            state_nxt;
    logic [IMEM_AW-1:0] pc;
    logic               pend;
    logic               wfi_seen;
    logic [1:0]         count;
    logic [63:0]        head;
    logic               pop;
    logic               wfi_xfer;
    logic               req;
    logic [2:0]         need;
    logic [2:0]         room;

    ifu_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pend),
        .pop   (pop),
        .flush (wfi_xfer),
        .din   (imem_ifu_rdata),
        .count (count),
        .head  (head)
    );

    assign ifu_idu_vld = (count != 2'd0) && (state == IFU_ST_FETCH);
    assign ifu_idu_ins = head;
    assign pop         = ifu_idu_vld && idu_ifu_rdy;
    assign wfi_xfer    = pop && is_wfi(head);

    // A pop this cycle frees a slot, so requests resume the cycle the IDU is ready again.
    assign need = {1'b0, count} + {2'b00, pend};
    assign room = 3'(FIFO_DEPTH) + {2'b00, pop};
    assign req  = (state == IFU_ST_FETCH) && !wfi_xfer && (need < room);

    assign ifu_imem_req  = req;
    assign ifu_imem_addr = pc;
    assign ifu_busy      = (state != IFU_ST_IDLE);
    assign ifu_done      = (state == IFU_ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IFU_ST_IDLE:  if (start) state_nxt = IFU_ST_FETCH;
            IFU_ST_FETCH: if (wfi_xfer) state_nxt = IFU_ST_DRAIN;
            IFU_ST_DRAIN: if (wfi_seen && !idu_ifu_wfi) state_nxt = IFU_ST_DONE;
            IFU_ST_DONE:  state_nxt = IFU_ST_IDLE;
            default:      state_nxt = IFU_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IFU_ST_IDLE;
            pc       <= '0;
            pend     <= 1'b0;
            wfi_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IFU_ST_IDLE) && start) pc <= start_pc;
            else if (req)                        pc <= pc + 1'b1;
            // req is never raised in a WFI transfer cycle, so no stale read gets pushed
            pend <= req;
            if (state != IFU_ST_DRAIN) wfi_seen <= 1'b0;
            else if (idu_ifu_wfi)      wfi_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: SRAM model plus a transaction-level scoreboard of the
// instruction stream, fetch addresses and in-flight word budget.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_pc;
    logic          ifu_imem_req;
    logic [AW-1:0] ifu_imem_addr;
    logic [63:0]   imem_ifu_rdata;
    logic          ifu_idu_vld;
    logic [63:0]   ifu_idu_ins;
    logic          idu_ifu_rdy;
    logic          idu_ifu_wfi;
    logic          ifu_busy;
    logic          ifu_done;

    ifu_fetch #(.IMEM_AW(AW), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_pc       (start_pc),
        .ifu_imem_req   (ifu_imem_req),
        .ifu_imem_addr  (ifu_imem_addr),
        .imem_ifu_rdata (imem_ifu_rdata),
        .ifu_idu_vld    (ifu_idu_vld),
        .ifu_idu_ins    (ifu_idu_ins),
        .idu_ifu_rdy    (idu_ifu_rdy),
        .idu_ifu_wfi    (idu_ifu_wfi),
        .ifu_busy       (ifu_busy),
        .ifu_done       (ifu_done)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:(1<<AW)-1];

    // Synchronous SRAM; garbage on idle cycles exposes any push at the wrong time.
    always @(posedge clk) begin
        if (ifu_imem_req) imem_ifu_rdata <= mem[ifu_imem_addr];
        else              imem_ifu_rdata <= {$urandom, $urandom};
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 1;

    bit            mon_en;
    logic [63:0]   exp_q[$];
    logic [AW-1:0] addr_log[$];
    logic [AW-1:0] exp_addr;
    int            issued, popped, n_req;
    int            first_req_cyc, first_vld_cyc, wfi_cyc, start_cyc;
    bit            wfi_xfered;
    logic          prev_vld, prev_rdy;
    logic [63:0]   prev_ins;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rand_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        if (w[63:56] == WFI_OP_CODE) w[63:56] = 8'h13;
        return w;
    endfunction

    task automatic mon_clear(input logic [AW-1:0] pc0);
        exp_q.delete();
        addr_log.delete();
        exp_addr      = pc0;
        issued        = 0;
        popped        = 0;
        n_req         = 0;
        first_req_cyc = -1;
        first_vld_cyc = -1;
        wfi_cyc       = -1;
        wfi_xfered    = 1'b0;
        prev_vld      = 1'b0;
        prev_rdy      = 1'b0;
        prev_ins      = '0;
    endtask

    task automatic monitor();
        logic [63:0] w;
        if (!mon_en) return;
        if (wfi_xfered) begin
            chk("vld_after_wfi", ifu_idu_vld, 0);
            chk("req_after_wfi", ifu_imem_req, 0);
        end else begin
            if (ifu_idu_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (ifu_idu_vld && prev_vld && !prev_rdy) chk("ins_hold", ifu_idu_ins, prev_ins);
            if (ifu_idu_vld && idu_ifu_rdy) begin
                popped++;
                if (exp_q.size() == 0) begin
                    chk("xfer_extra", ifu_idu_vld, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("xfer", ifu_idu_ins, w);
                    if (w[63:56] == WFI_OP_CODE) begin
                        wfi_xfered = 1'b1;
                        wfi_cyc    = cyc;
                    end
                end
            end
            if (wfi_xfered) begin
                chk("req_on_wfi", ifu_imem_req, 0);
            end else if (ifu_imem_req) begin
                if (first_req_cyc < 0) first_req_cyc = cyc;
                chk("addr", ifu_imem_addr, exp_addr);
                addr_log.push_back(ifu_imem_addr);
                exp_addr++;
                issued++;
                n_req++;
                chk("in_flight", (issued - popped) <= 2, 1);
            end
        end
        prev_vld = ifu_idu_vld;
        prev_rdy = idu_ifu_rdy;
        prev_ins = ifu_idu_ins;
    endtask

    // Inputs are applied just after posedge; half() samples at negedge, fin() moves on.
    task automatic half();
        if (rdy_mode == 2) idu_ifu_rdy = ($urandom_range(0, 3) != 0);
        else               idu_ifu_rdy = (rdy_mode == 1);
        @(negedge clk);
        monitor();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},  ifu_imem_req, 0);
        chk({tag, "_addr"}, ifu_imem_addr, 0);
        chk({tag, "_vld"},  ifu_idu_vld, 0);
        chk({tag, "_ins"},  ifu_idu_ins, 0);
        chk({tag, "_busy"}, ifu_busy, 0);
        chk({tag, "_done"}, ifu_done, 0);
    endtask

    task automatic load_prog(input logic [AW-1:0] pc0, input int n);
        logic [AW-1:0] a;
        a = pc0;
        for (int i = 0; i < n; i++) begin
            mem[a] = rand_word();
            exp_q.push_back(mem[a]);
            a++;
        end
        mem[a] = {WFI_OP_CODE, 24'h0, $urandom};
        exp_q.push_back(mem[a]);
        a++;
        mem[a] = rand_word();
    endtask

    // kind: 0 plain, 1 stall for 12 cycles with a start pulse in FETCH, 2 start pulse in DRAIN
    task automatic run_prog(input logic [AW-1:0] pc0, input int n, input int mode, input int kind);
        int k, pre, hold;
        mon_clear(pc0);
        load_prog(pc0, n);
        mon_en   = 1'b1;
        rdy_mode = (kind == 1) ? 0 : mode;
        start    = 1'b1;
        start_pc = pc0;
        start_cyc = cyc;
        half();
        chk("idle_req", ifu_imem_req, 0);
        fin();
        start = 1'b0;
        if (kind == 1) begin
            for (int i = 0; i < 12; i++) begin
                start    = (i == 5);
                start_pc = 10'h155;
                step();
            end
            start = 1'b0;
            chk("stall_nreq", n_req, 2);
            half();
            chk("stall_req", ifu_imem_req, 0);
            fin();
            rdy_mode = 1;
            half();
            chk("resume_req", ifu_imem_req, 1);
            fin();
        end
        k = 0;
        while (!wfi_xfered && k < 300) begin
            step();
            k++;
        end
        chk("wfi_seen_in_time", wfi_xfered, 1);
        pre  = $urandom_range(0, 2);
        hold = $urandom_range(1, 3);
        if (kind == 2) begin
            start    = 1'b1;
            start_pc = 10'($urandom);
        end
        for (int i = 0; i < pre; i++) begin
            idu_ifu_wfi = 1'b0;
            half();
            chk("done_early", ifu_done, 0);
            chk("busy_drain", ifu_busy, 1);
            fin();
            start = 1'b0;
        end
        for (int i = 0; i < hold; i++) begin
            idu_ifu_wfi = 1'b1;
            half();
            chk("done_wfi_hi", ifu_done, 0);
            fin();
            start = 1'b0;
        end
        idu_ifu_wfi = 1'b0;
        half();
        chk("done_wfi_fall", ifu_done, 0);
        fin();
        half();
        chk("done_pulse", ifu_done, 1);
        chk("busy_done", ifu_busy, 1);
        fin();
        half();
        chk("done_clr", ifu_done, 0);
        chk("busy_idle", ifu_busy, 0);
        fin();
        half();
        chk("idle_quiet", ifu_imem_req, 0);
        fin();
        chk("leftover", exp_q.size(), 0);
        mon_en = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        start_pc    = '0;
        idu_ifu_rdy = 1'b0;
        idu_ifu_wfi = 1'b0;
        mon_en      = 1'b0;
        mon_clear('0);
        for (int i = 0; i < (1 << AW); i++) mem[i] = rand_word();
        #1;
        repeat (3) step();
        half();
        check_reset_outputs("rst");
        fin();
        rst = 1'b0;
        step();

        // straight-line program, rdy held high: latency and back-to-back transfers
        run_prog(10'h010, 5, 1, 0);
        chk("lat_req", first_req_cyc - start_cyc, 1);
        chk("lat_vld", first_vld_cyc - start_cyc, 3);
        chk("burst",   wfi_cyc - first_vld_cyc, 5);

        // stalled IDU with an ignored start pulse
        run_prog(10'h040, 6, 1, 1);

        // address wrap
        run_prog(10'h3FE, 4, 1, 0);
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] ea;
            ea = 10'h3FE + 10'(i);
            chk("wrap_addr", (i < addr_log.size()) ? 64'(addr_log[i]) : 64'hx, ea);
        end

        // reset while a read is in flight
        mon_clear(10'h080);
        load_prog(10'h080, 6);
        rdy_mode = 1;
        start    = 1'b1;
        start_pc = 10'h080;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        half();
        check_reset_outputs("midrst");
        fin();
        for (int i = 0; i < 3; i++) begin
            half();
            chk("stale_vld", ifu_idu_vld, 0);
            fin();
        end
        run_prog(10'h0C0, 4, 1, 0);

        // start pulse ignored while draining
        run_prog(10'h100, 3, 1, 2);

        for (int t = 0; t < 10; t++) begin
            run_prog(10'($urandom), $urandom_range(0, 6), 2, ($urandom_range(0, 1) == 1) ? 2 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: the transmitting end of the IFU→IDU instruction handshake. It reads 64-bit instruction words from the synchronous instruction SRAM, starting at a host-supplied PC. Words are buffered in a 2-entry queue and presented to the IDU with `ifu_idu_vld`/`ifu_idu_ins`, throttled by `idu_ifu_rdy`. Fetching stops when a WFI instruction is handed over; the block signals `ifu_done` once the IDU has retired that WFI.

## Interface
- `IMEM_AW`, 10: instruction SRAM word-address width.
- `FIFO_DEPTH`, 2: instruction queue depth, fixed at 2 for this revision.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  host pulse; sampled only in IDLE.
- `start_pc`  in  IMEM_AW  first fetch word address; sampled with `start`.
- `ifu_imem_req`  out  1  SRAM read enable.
- `ifu_imem_addr`  out  IMEM_AW  SRAM word address.
- `imem_ifu_rdata`  in  64  read data, valid exactly 1 cycle after `ifu_imem_req`.
- `ifu_idu_vld`  out  1  instruction valid.
- `ifu_idu_ins`  out  64  instruction word (queue head).
- `idu_ifu_rdy`  in  1  IDU accepts; transfer = `ifu_idu_vld & idu_ifu_rdy`.
- `idu_ifu_wfi`  in  1  IDU currently holds a valid WFI.
- `ifu_busy`  out  1  state != IDLE.
- `ifu_done`  out  1  one-cycle pulse at WFI completion.

## Operation
- States:
  - IDLE: `start` → FETCH; PC ← `start_pc`.
  - FETCH: a transferred word whose opcode (`OP_RNG`) equals `WFI_OP_CODE` → DRAIN.
  - DRAIN: `idu_ifu_wfi` has been seen high and is now low → DONE.
  - DONE: one cycle, `ifu_done`=1 → IDLE.
- Issue rule (FETCH only): `ifu_imem_req`=1 when `count + pend - pop < FIFO_DEPTH`.
  - `count` = queue occupancy; `pend` = read issued last cycle; `pop` = transfer this cycle.
  - Also suppressed in the same cycle a WFI transfers.
- `ifu_imem_addr` = PC. PC increments by 1 per issued request and wraps from 2^IMEM_AW−1 to 0.
- Return data: when `pend`=1, `imem_ifu_rdata` is pushed into the queue. The issue rule guarantees this never overflows.
- Presentation: `ifu_idu_vld` = (count≠0) and state = FETCH. `ifu_idu_ins` = queue head, held stable while vld & !rdy.
- WFI transfer:
  - Flush the queue.
  - Discard any pending read: the next-cycle push is suppressed via the `pend` flag.
  - No instruction after a WFI is ever presented.
- `start` outside IDLE is ignored.
- DRAIN exits only after a high→low sequence on `idu_ifu_wfi`. A WFI still high on DRAIN entry is tracked by a `wfi_seen` flag.

## Timing
- Reset values: all outputs 0, PC=0, count=0, pend=0, `wfi_seen`=0, state IDLE.
- Reset mid-operation clears everything next edge, including an in-flight SRAM read, whose data is dropped.
- Start latency:
  - `start` at cycle t → `ifu_imem_req` with addr=`start_pc` at t+1.
  - Data arrives at t+2 and is queued at end of t+2.
  - `ifu_idu_vld` asserts at t+3.
- Throughput: with `idu_ifu_rdy` held high, one transfer per cycle, no bubbles after the first.
- Stall: when `idu_ifu_rdy`=0, the queue fills (2 words) and requests stop. They resume in the same cycle `rdy` returns (pop credit).
- Simultaneous push and pop: count unchanged. Pop has priority in the head update.
- `ifu_done` asserts 1 cycle after the DRAIN exit condition. `ifu_busy` drops the cycle after DONE.

## Structure
- Shared define header (existing): `OP_RNG`, `WFI_OP_CODE`, plus new `IFU_ST_IDLE/FETCH/DRAIN/DONE` 2-bit state encodings.
- One sub-module, `ifu_fifo`:
  - 2-entry, 64-bit synchronous FIFO with push/pop/flush.
  - Outputs: `count`, `head`.
  - Flush has priority over push.

## Test plan
- Reset then `start` with `start_pc`=0x010, rdy=1, SRAM holds 5 non-WFI words then WFI at 0x015 → six transfers on consecutive cycles beginning t+3. The WFI is last; no request to 0x016 is visible to the IDU; `ifu_done` pulses after `idu_ifu_wfi` high→low.
- rdy low for 10 cycles after the first vld → exactly 2 further requests, then `ifu_imem_req`=0. `ifu_idu_ins` is stable throughout. Order is preserved on release with no duplicates.
- `start_pc`=0x3FE (IMEM_AW=10) → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- WFI accepted while a read is pending and the queue holds 1 word → both are discarded, `ifu_idu_vld`=0 in DRAIN.
- `rst` asserted mid-FETCH with a pending read → next cycle all outputs 0. Stale rdata does not appear after a subsequent `start`.
- `start` pulsed during FETCH and DRAIN → no PC change, no effect.
